mem_writer: RTL and testbench

MEM_WRITER -- requirements
Module: mem_writer

---
 rtl/mem_pkg.sv | 15 +
 rtl/ram_sp.sv | 33 +++
 rtl/mem_writer.sv | 133 +++++++++++++
 tb/tb_mem_writer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the burst memory writer.
// Holds the writer FSM state type and the constants that fix its encoding.
package mem_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'b00;
  localparam logic [1:0] ST_LOAD_ENC = 2'b01;
  localparam logic [1:0] ST_DONE_ENC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    LOAD = ST_LOAD_ENC,
    DONE = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/ram_sp.sv
// Simple dual-ported storage: one synchronous write port, one synchronous
// read port with one cycle of latency. A read of the address being written
// in the same cycle returns the old contents. Contents and read data are
// not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : registered read data
module ram_sp #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [DEPTH_LOG-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_writer.sv
// Burst memory writer. A start pulse latches a base address and a word
// count; words offered on in_valid/in_data are then stored at consecutive
// addresses (wrapping modulo DEPTH) until the count is reached, after which
// done pulses for one cycle. Storage can be read back at any time.
//   clk, rst            : clock, async active-high reset
//   start               : begin a burst (honoured only when idle)
//   base_addr, length   : burst start address and word count
//   in_valid, in_data   : incoming word
//   in_ready            : word accepted this cycle when in_valid is high
//   busy, done          : burst in progress / one-cycle completion pulse
//   wr_count            : words written in the current or last burst
//   addr_rd, data_out   : read-back port, one cycle latency
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting words until length have been written
// DONE  | single-cycle completion, done asserted
module mem_writer
  import mem_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DEPTH_LOG-1:0] base_addr,
  input  logic [DEPTH_LOG:0]   length,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 done,
  output logic [DEPTH_LOG:0]   wr_count,
  input  logic [DEPTH_LOG-1:0] addr_rd,
  output logic [WIDTH-1:0]     data_out
);

  localparam int LEN_W = DEPTH_LOG + 1;

  state_t               state, state_next;
  logic [DEPTH_LOG-1:0] ptr;
  logic [DEPTH_LOG-1:0] ptr_inc;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     len_clamped;
  logic [LEN_W-1:0]     wr_count_inc;
  logic                 handshake;

  // A burst can never write more than the whole memory once.
  assign len_clamped  = (length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : length;
  assign ptr_inc      = (ptr == DEPTH_LOG'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign wr_count_inc = wr_count + 1'b1;
  assign handshake    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (length == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (handshake && (wr_count_inc == len_q)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      len_q    <= '0;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wr_count <= '0;
            if (length != '0) begin
              ptr   <= base_addr;
              len_q <= len_clamped;
            end
          end
        end
        LOAD: begin
          if (handshake) begin
            ptr      <= ptr_inc;
            wr_count <= wr_count_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  ram_sp #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_ram (
    .clk   (clk),
    .we    (handshake),
    .waddr (ptr),
    .wdata (in_data),
    .raddr (addr_rd),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_mem_writer.sv
// Bench for mem_writer: directed bursts plus randomized bursts, each checked
// against an array model of memory and the burst rules.
module tb_mem_writer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int DL    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [DL-1:0]    base_addr = '0;
  logic [DL:0]      length = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [DL:0]      wr_count;
  logic [DL-1:0]    addr_rd = '0;
  logic [WIDTH-1:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] model_mem [DEPTH];
  logic [WIDTH-1:0] fixed_data [$];
  bit               valid_pat [$];

  mem_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG(DL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count),
    .addr_rd   (addr_rd),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge. Issues start, feeds words and checks the burst
  // outcome; the model memory records each accepted word.
  task automatic run_burst(input int base, input int len, input int valid_pct, input bit poke);
    int eff;
    int accepted;
    int cycles;
    bit v;
    logic [WIDTH-1:0] d;
    eff = (len > DEPTH) ? DEPTH : len;
    start     = 1'b1;
    base_addr = DL'(base);
    length    = (DL+1)'(len);
    in_valid  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (eff == 0) begin
      check("zero_done", done, 1);
      check("zero_ready", in_ready, 0);
      check("zero_busy", busy, 0);
      check("zero_count", wr_count, 0);
      @(negedge clk);
      check("zero_done_once", done, 0);
      check("zero_ready_after", in_ready, 0);
      return;
    end
    check("load_busy", busy, 1);
    accepted = 0;
    cycles   = 0;
    while (accepted < eff && cycles < 400) begin
      check("load_ready", in_ready, 1);
      check("load_no_done", done, 0);
      check("load_count", wr_count, accepted);
      if (valid_pat.size() > 0) v = valid_pat.pop_front();
      else v = ($urandom_range(99) < valid_pct);
      if (v && fixed_data.size() > 0) d = fixed_data.pop_front();
      else d = WIDTH'($urandom);
      in_valid = v;
      in_data  = d;
      if (poke) begin
        start     = ($urandom_range(2) == 0);
        base_addr = DL'($urandom);
        length    = (DL+1)'($urandom);
      end
      @(negedge clk);
      if (v) begin
        model_mem[(base + accepted) % DEPTH] = d;
        accepted++;
      end
      cycles++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("burst_accepted", accepted, eff);
    check("done_pulse", done, 1);
    check("done_ready", in_ready, 0);
    check("done_busy", busy, 0);
    check("done_count", wr_count, eff);
    @(negedge clk);
    check("done_once", done, 0);
    check("idle_busy", busy, 0);
    check("hold_count", wr_count, eff);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      addr_rd = DL'(a);
      @(negedge clk);
      check($sformatf("rd%0d", a), data_out, model_mem[a]);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", wr_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Give every word a known value.
    run_burst(0, 16, 100, 0);
    read_all();

    fixed_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_burst(0, 4, 100, 0);
    read_all();

    fixed_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    run_burst(14, 4, 100, 0);
    read_all();

    run_burst(3, 0, 100, 0);
    read_all();

    valid_pat = '{1, 0, 0, 1, 0, 1};
    run_burst(8, 3, 100, 1);
    read_all();

    // Reset in the middle of a burst.
    start = 1'b1; base_addr = '0; length = 5'd8;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [WIDTH-1:0] d;
      d = WIDTH'($urandom);
      check("abort_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      model_mem[i] = d;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready_low", in_ready, 0);
    check("abort_done", done, 0);
    check("abort_count", wr_count, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_idle", busy, 0);
    end
    read_all();

    // Read and write of the same address in one cycle.
    fixed_data = '{8'h00};
    run_burst(5, 1, 100, 0);
    start = 1'b1; base_addr = 4'd5; length = 5'd1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    addr_rd  = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    check("raw_old", data_out, 8'h00);
    check("raw_done", done, 1);
    @(negedge clk);
    check("raw_new", data_out, 8'h5A);
    model_mem[5] = 8'h5A;

    repeat (12) begin
      run_burst(int'($urandom_range(15)), int'($urandom_range(31)), int'($urandom_range(100, 20)), 1);
    end
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
